// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// State encoding, datapath widths and default reset/halt values.
package fetch_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 16'h0000;
    localparam logic [3:0]      HLT_OP_DEF   = 4'hF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_inc16.sv
// 16-bit +2 incrementer built as a ripple chain of 1-bit full adders.
// The final carry is dropped so 16'hFFFE wraps to 16'h0000.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Single-bit sum and carry.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

module pc_inc16
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] a,
    output logic [PC_W-1:0] y
);

    logic [PC_W-1:0] c;
    logic            cout_unused;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < PC_W; i++) begin : g_bit
        logic co;
        full_adder_1bit u_fa (
            .a   (a[i]),
            .b   (i == 1),
            .cin (c[i]),
            .s   (y[i]),
            .cout(co)
        );
        if (i < PC_W - 1) begin : g_chain
            assign c[i+1] = co;
        end else begin : g_last
            assign cout_unused = co;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: PC, imem request, branch redirect, halt on HLT.
// Optional odd-target check enabled by defining PC_ALIGN_CHK_EN.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [3:0]      HLT_OP   = HLT_OP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rdy,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               fetch_valid,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic [PC_W-1:0]    fetch_pc,
    output logic [PC_W-1:0]    pc_plus2,
    output logic               halted,
    output logic               align_err
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            redir_pend_q, redir_pend_d;
    logic [PC_W-1:0] redir_pc_q, redir_pc_d;
    logic            is_hlt;
    logic            br_bad;

    pc_inc16 u_inc (
        .a(pc_q),
        .y(pc_plus2)
    );

    assign is_hlt      = (imem_data[INSTR_W-1 -: 4] == HLT_OP);
    assign imem_addr   = pc_q;
    assign fetch_pc    = pc_q;
    assign fetch_instr = imem_data;
    assign halted      = !rst && (state_q == HALTED);

`ifdef PC_ALIGN_CHK_EN
    logic align_err_q, align_err_d;

    assign br_bad    = br_target[0];
    assign align_err = !rst && align_err_q;

    // Sticky odd-target flag, cleared only by reset.
    always_comb begin
        align_err_d = align_err_q | (br_taken & br_bad);
        if (rst) align_err_d = 1'b0;
    end

    // Alignment error register.
    always_ff @(posedge clk) begin
        align_err_q <= align_err_d;
    end
`else
    assign br_bad    = 1'b0;
    assign align_err = 1'b0;
`endif

    // Next-state, next-pc and request/delivery outputs.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        imem_req     = 1'b0;
        fetch_valid  = 1'b0;
        if (rst) begin
            state_d      = RUN;
            pc_d         = RESET_PC;
            redir_pend_d = 1'b0;
        end else if (br_taken && br_bad) begin
            imem_req     = (state_q == WAIT);
            state_d      = HALTED;
            redir_pend_d = 1'b0;
        end else if (br_taken) begin
            unique case (state_q)
                RUN: begin
                    pc_d = br_target;
                end
                WAIT: begin
                    imem_req = 1'b1;
                    if (imem_rdy) begin
                        pc_d         = br_target;
                        redir_pend_d = 1'b0;
                        state_d      = RUN;
                    end else begin
                        redir_pend_d = 1'b1;
                        redir_pc_d   = br_target;
                    end
                end
                HALTED: begin
                    pc_d    = br_target;
                    state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end else begin
            unique case (state_q)
                RUN: begin
                    imem_req = !stall;
                    if (!stall) begin
                        if (imem_rdy) begin
                            fetch_valid = 1'b1;
                            pc_d        = pc_plus2;
                            if (is_hlt) state_d = HALTED;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    imem_req = 1'b1;
                    if (imem_rdy) begin
                        state_d = RUN;
                        if (redir_pend_q) begin
                            pc_d         = redir_pc_q;
                            redir_pend_d = 1'b0;
                        end else if (!stall) begin
                            fetch_valid = 1'b1;
                            pc_d        = pc_plus2;
                            if (is_hlt) state_d = HALTED;
                        end
                    end
                end
                HALTED: begin
                    imem_req = 1'b0;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        state_q      <= state_d;
        pc_q         <= pc_d;
        redir_pend_q <= redir_pend_d;
        redir_pc_q   <= redir_pc_d;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed table-driven bench for pc_fetch_unit.
// Honours PC_ALIGN_CHK_EN in the alignment sequence.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, br_taken, imem_rdy;
    logic [15:0] br_target, imem_data;
    logic        imem_req, fetch_valid, halted, align_err;
    logic [15:0] imem_addr, fetch_instr, fetch_pc, pc_plus2;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_data  (imem_data),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .fetch_pc   (fetch_pc),
        .pc_plus2   (pc_plus2),
        .halted     (halted),
        .align_err  (align_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        br;
        logic [15:0] tgt;
        logic        rdy;
        logic [15:0] data;
        logic        req;
        logic        ck_req;
        logic [15:0] addr;
        logic        val;
        logic        hlt;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic st, logic br, logic [15:0] tgt,
                                logic rdy, logic [15:0] data, logic req,
                                logic ck_req, logic [15:0] addr,
                                logic val, logic hlt);
        vec_t v;
        v.st = st; v.br = br; v.tgt = tgt; v.rdy = rdy; v.data = data;
        v.req = req; v.ck_req = ck_req; v.addr = addr;
        v.val = val; v.hlt = hlt;
        return v;
    endfunction

    task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(logic st, logic br, logic [15:0] tgt,
                         logic rdy, logic [15:0] data);
        stall = st; br_taken = br; br_target = tgt;
        imem_rdy = rdy; imem_data = data;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 16'h0, 1, 16'h0);

        tv.push_back(mk(0,0,16'h0000,1,16'h1111, 1,1,16'h0000,1,0));
        tv.push_back(mk(0,0,16'h0000,1,16'h2222, 1,1,16'h0002,1,0));
        tv.push_back(mk(0,0,16'h0000,0,16'h0000, 1,1,16'h0004,0,0));
        tv.push_back(mk(1,0,16'h0000,0,16'h0000, 1,1,16'h0004,0,0));
        tv.push_back(mk(0,0,16'h0000,0,16'h0000, 1,1,16'h0004,0,0));
        tv.push_back(mk(0,0,16'h0000,1,16'h3333, 1,1,16'h0004,1,0));
        tv.push_back(mk(0,0,16'h0000,1,16'h6666, 1,1,16'h0006,1,0));
        tv.push_back(mk(1,1,16'h0040,1,16'h7777, 0,0,16'h0008,0,0));
        tv.push_back(mk(0,0,16'h0000,1,16'h8888, 1,1,16'h0040,1,0));
        tv.push_back(mk(0,1,16'h0010,1,16'h9999, 0,0,16'h0042,0,0));
        tv.push_back(mk(0,0,16'h0000,0,16'h0000, 1,1,16'h0010,0,0));
        tv.push_back(mk(0,1,16'h0020,0,16'h0000, 1,1,16'h0010,0,0));
        tv.push_back(mk(0,0,16'h0000,0,16'h0000, 1,1,16'h0010,0,0));
        tv.push_back(mk(0,0,16'h0000,1,16'h5555, 1,1,16'h0010,0,0));
        tv.push_back(mk(0,0,16'h0000,1,16'hF000, 1,1,16'h0020,1,0));
        tv.push_back(mk(0,0,16'h0000,1,16'h1234, 0,1,16'h0022,0,1));
        tv.push_back(mk(1,0,16'h0000,1,16'h1234, 0,1,16'h0022,0,1));
        tv.push_back(mk(0,1,16'h0100,1,16'h1234, 0,1,16'h0022,0,1));
        tv.push_back(mk(0,0,16'h0000,1,16'h0001, 1,1,16'h0100,1,0));
        tv.push_back(mk(0,0,16'h0000,0,16'h0000, 1,1,16'h0102,0,0));
        tv.push_back(mk(0,1,16'h0200,1,16'hAAAA, 1,1,16'h0102,0,0));
        tv.push_back(mk(0,0,16'h0000,1,16'hBBBB, 1,1,16'h0200,1,0));
        tv.push_back(mk(0,0,16'h0000,0,16'h0000, 1,1,16'h0202,0,0));
        tv.push_back(mk(1,0,16'h0000,1,16'hCCCC, 1,1,16'h0202,0,0));
        tv.push_back(mk(0,0,16'h0000,1,16'hDDDD, 1,1,16'h0202,1,0));
        tv.push_back(mk(0,1,16'hFFFE,1,16'hEEEE, 0,0,16'h0204,0,0));
        tv.push_back(mk(0,0,16'h0000,1,16'h0ABC, 1,1,16'hFFFE,1,0));
        tv.push_back(mk(0,0,16'h0000,1,16'h0DEF, 1,1,16'h0000,1,0));

        @(negedge clk);
        #1;
        chk("rst_req",   16'(imem_req),    16'h0);
        chk("rst_valid", 16'(fetch_valid), 16'h0);
        chk("rst_halt",  16'(halted),      16'h0);
        chk("rst_align", 16'(align_err),   16'h0);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst = 1'b0;
            drive(tv[i].st, tv[i].br, tv[i].tgt, tv[i].rdy, tv[i].data);
            #1;
            chk($sformatf("v%0d_addr", i), imem_addr, tv[i].addr);
            chk($sformatf("v%0d_valid", i), 16'(fetch_valid), 16'(tv[i].val));
            chk($sformatf("v%0d_halt", i), 16'(halted), 16'(tv[i].hlt));
            chk($sformatf("v%0d_pc2", i), pc_plus2, tv[i].addr + 16'd2);
            if (tv[i].ck_req)
                chk($sformatf("v%0d_req", i), 16'(imem_req), 16'(tv[i].req));
            if (tv[i].val) begin
                chk($sformatf("v%0d_pc", i), fetch_pc, tv[i].addr);
                chk($sformatf("v%0d_instr", i), fetch_instr, tv[i].data);
            end
        end

        // Reset while a request is outstanding abandons it.
        @(negedge clk);
        drive(0, 0, 16'h0, 0, 16'h0);
        #1;
        chk("mw_req",  16'(imem_req), 16'h1);
        chk("mw_addr", imem_addr, 16'h0002);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mw_rst_req",   16'(imem_req),    16'h0);
        chk("mw_rst_valid", 16'(fetch_valid), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 16'h0, 1, 16'h4321);
        #1;
        chk("mw_after_addr",  imem_addr, 16'h0000);
        chk("mw_after_valid", 16'(fetch_valid), 16'h1);
        chk("mw_after_req",   16'(imem_req), 16'h1);

        // Odd branch target.
        @(negedge clk);
        drive(0, 1, 16'h0031, 1, 16'h0000);
        #1;
        chk("odd_br_valid", 16'(fetch_valid), 16'h0);
        @(negedge clk);
        drive(0, 0, 16'h0, 1, 16'h0000);
        #1;
`ifdef PC_ALIGN_CHK_EN
        chk("odd_align", 16'(align_err), 16'h1);
        chk("odd_halt",  16'(halted),    16'h1);
        chk("odd_req",   16'(imem_req),  16'h0);
        chk("odd_addr",  imem_addr,      16'h0002);
        @(negedge clk);
        #1;
        chk("odd_sticky", 16'(align_err), 16'h1);
`else
        chk("odd_align", 16'(align_err), 16'h0);
        chk("odd_halt",  16'(halted),    16'h0);
        chk("odd_addr",  imem_addr,      16'h0031);
        chk("odd_valid", 16'(fetch_valid), 16'h1);
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2_align", 16'(align_err), 16'h0);
        chk("rst2_halt",  16'(halted),    16'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst2_addr", imem_addr, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage front end: owns the program counter, issues requests to instruction memory, and delivers fetched instructions to the IF/ID register. It consumes the branch target produced by the branch-address adder in decode and redirects fetch on a taken branch. It also supplies PC+2 to that adder as its base operand.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- HLT_OP, 4'hF, opcode (instr[15:12]) that halts fetch
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit holds fetch
- br_taken  in  1  one-cycle pulse from decode: redirect to br_target
- br_target  in  16  branch target from branch-address adder
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  16  fetch address
- imem_rdy  in  1  memory returns imem_data this cycle
- imem_data  in  16  instruction word
- fetch_valid  out  1  fetch_instr/fetch_pc valid for IF/ID capture this cycle
- fetch_instr  out  16  instruction delivered
- fetch_pc  out  16  address of fetch_instr
- pc_plus2  out  16  fetch_pc + 2, to branch-address adder and IF/ID
- halted  out  1  fetch stopped on HLT
- align_err  out  1  odd branch target seen (only with PC_ALIGN_CHK_EN; else tied 0)

## Operation
- States: RUN, WAIT, HALTED. Registers: pc, state, redir_pend, redir_pc.
- Reset: pc=RESET_PC, state=RUN, redir_pend=0; during reset cycle imem_req=0, fetch_valid=0, halted=0, align_err=0.
- RUN, stall=0: imem_req=1, imem_addr=pc. imem_rdy=1 -> fetch_valid=1, fetch_instr=imem_data, fetch_pc=pc, pc<=pc+2. imem_rdy=0 -> go WAIT.
- RUN, stall=1: imem_req=0, fetch_valid=0, pc holds.
- WAIT: imem_req=1, imem_addr held stable until imem_rdy; stall ignored (request already outstanding). On rdy: if redir_pend, discard data (fetch_valid=0), pc<=redir_pc, clear redir_pend; else deliver as RUN (stall=1 at that cycle holds pc and suppresses fetch_valid; refetch next). Return to RUN.
- br_taken: highest priority, overrides stall. In RUN: fetch this cycle discarded (fetch_valid=0), pc<=br_target. In WAIT without rdy: redir_pend<=1, redir_pc<=br_target. In WAIT with rdy same cycle: discard data, pc<=br_target, RUN. In HALTED: halt was speculative -> pc<=br_target, halted<=0, RUN.
- HLT: delivered instruction with opcode HLT_OP is presented (fetch_valid=1), then state<=HALTED; imem_req=0, pc holds pc+2, halted=1. Only rst or br_taken leaves HALTED.
- Arithmetic: 16-bit, pc+2 wraps 16'hFFFE -> 16'h0000, no carry out; bit 0 of pc always 0 after reset unless br_target odd.

## Timing
- Zero-wait memory: one instruction per cycle, fetch_valid combinational from imem_rdy in RUN/WAIT.
- Redirect latency: br_taken in cycle N -> imem_addr=br_target in cycle N+1.
- imem_req/imem_addr never change while a request is outstanding without rdy.
- rst mid-WAIT: outstanding request abandoned; memory must tolerate req drop.

## Configuration
- PC_ALIGN_CHK_EN defined: br_taken with br_target[0]=1 sets align_err (sticky until rst), enters HALTED, pc unchanged.
- Undefined: br_target used as-is, align_err tied 0, no extra state.

## Structure
- fetch_pkg: state enum (RUN/WAIT/HALTED), PC_W=16, INSTR_W=16, default RESET_PC, HLT_OP.
- Sub-module pc_inc16: 16-bit +2 incrementer built from full_adder_1bit ripple chain, carry-out discarded.

## Test plan
- rst 1 cycle, imem_rdy=1 constant -> imem_addr 0x0000,0x0002,0x0004 consecutive cycles, fetch_valid=1 each.
- imem_rdy low 3 cycles at pc=0x0004 -> imem_addr held 0x0004, fetch_valid=0, then delivered with fetch_pc=0x0004.
- br_taken=1, br_target=0x0040 with stall=1 at pc=0x0008 -> no fetch_valid that cycle, next imem_addr=0x0040.
- br_taken during WAIT at 0x0010, rdy 2 cycles later -> data discarded, next imem_addr=br_target.
- imem_data=0xF000 at 0x0020 -> delivered once, then halted=1, imem_req=0; later br_taken to 0x0100 -> resumes at 0x0100.
- pc=0xFFFE, rdy=1 -> next imem_addr=0x0000; with PC_ALIGN_CHK_EN, br_target=0x0031 -> align_err=1, halted=1.
